// File: rtl/led_scan_decoder.sv
// Decodes a one-hot LED scanner pattern into a tracked position and sweep direction.
// Flags illegal samples, reports end reversals, and counts errors and full sweeps.
module led_scan_decoder #(
    parameter int ERR_CNT_W = 8
) (
    input  logic                 CLOCK_50,
    input  logic                 reset,
    input  logic                 sample_en,
    input  logic [9:0]           LEDR_IN,
    output logic [3:0]           position,
    output logic                 pos_valid,
    output logic                 direction,
    output logic                 bounce,
    output logic                 error,
    output logic [ERR_CNT_W-1:0] error_count,
    output logic [ERR_CNT_W-1:0] sweep_count,
    output logic [1:0]           state
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SYNC = 2'd1,
        UP   = 2'd2,
        DOWN = 2'd3
    } state_t;

    state_t cur_state;
    state_t nxt_state;

    logic       one_hot;
    logic [3:0] idx;
    logic       same_step;
    logic       inc_step;
    logic       dec_step;
    logic       take;
    logic       fault;
    logic       reversal;
    logic       sweep_done;

    assign state = cur_state;

    // Sample interface: sample_en is a single-cycle strobe with no backpressure;
    // LEDR_IN is consumed on every rising edge where sample_en is high.
    assign one_hot = (LEDR_IN != 10'd0) && ((LEDR_IN & (LEDR_IN - 10'd1)) == 10'd0);

    always_comb begin
        idx = 4'd0;
        for (int i = 0; i < 10; i++) begin
            if (LEDR_IN[i]) begin
                idx = 4'(i);
            end
        end
    end

    assign same_step = (idx == position);
    assign inc_step  = (idx == position + 4'd1);
    assign dec_step  = (position != 4'd0) && (idx == position - 4'd1);

    always_comb begin
        nxt_state  = cur_state;
        take       = 1'b0;
        fault      = 1'b0;
        reversal   = 1'b0;
        sweep_done = 1'b0;
        if (!one_hot) begin
            fault = 1'b1;
        end else begin
            case (cur_state)
                IDLE: begin
                    take = 1'b1;
                    if (idx == 4'd0) begin
                        nxt_state = UP;
                    end else if (idx == 4'd9) begin
                        nxt_state = DOWN;
                    end else begin
                        nxt_state = SYNC;
                    end
                end
                SYNC: begin
                    if (same_step) begin
                        nxt_state = SYNC;
                    end else if (inc_step) begin
                        take      = 1'b1;
                        nxt_state = UP;
                    end else if (dec_step) begin
                        take      = 1'b1;
                        nxt_state = DOWN;
                    end else begin
                        fault = 1'b1;
                    end
                end
                UP: begin
                    if (same_step) begin
                        nxt_state = UP;
                    end else if (inc_step && position < 4'd9) begin
                        take = 1'b1;
                    end else if (position == 4'd9 && idx == 4'd8) begin
                        take      = 1'b1;
                        reversal  = 1'b1;
                        nxt_state = DOWN;
                    end else begin
                        fault = 1'b1;
                    end
                end
                DOWN: begin
                    if (same_step) begin
                        nxt_state = DOWN;
                    end else if (dec_step) begin
                        take = 1'b1;
                    end else if (position == 4'd0 && idx == 4'd1) begin
                        // Low-end reversal closes a full 0..9..0 sweep.
                        take       = 1'b1;
                        reversal   = 1'b1;
                        sweep_done = 1'b1;
                        nxt_state  = UP;
                    end else begin
                        fault = 1'b1;
                    end
                end
                default: fault = 1'b1;
            endcase
        end
        if (fault) begin
            nxt_state = IDLE;
            take      = 1'b0;
            reversal  = 1'b0;
        end
    end

    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            cur_state   <= IDLE;
            position    <= 4'd0;
            pos_valid   <= 1'b0;
            direction   <= 1'b1;
            bounce      <= 1'b0;
            error       <= 1'b0;
            error_count <= '0;
            sweep_count <= '0;
        end else begin
            bounce <= 1'b0;
            error  <= 1'b0;
            if (sample_en) begin
                cur_state <= nxt_state;
                pos_valid <= !fault;
                bounce    <= reversal;
                error     <= fault;
                if (take) begin
                    position <= idx;
                end
                if (nxt_state == UP) begin
                    direction <= 1'b1;
                end else if (nxt_state == DOWN) begin
                    direction <= 1'b0;
                end
                if (fault && error_count != {ERR_CNT_W{1'b1}}) begin
                    error_count <= error_count + ERR_CNT_W'(1);
                end
                if (sweep_done) begin
                    sweep_count <= sweep_count + ERR_CNT_W'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_led_scan_decoder.sv
// Bench for led_scan_decoder: directed scenarios plus randomized samples checked
// against an arithmetic model of the scanner tracking rules.
module tb_led_scan_decoder;

    localparam int W = 8;
    localparam int ST_IDLE = 0;
    localparam int ST_SYNC = 1;
    localparam int ST_UP   = 2;
    localparam int ST_DOWN = 3;

    logic         clk = 1'b0;
    logic         rst;
    logic         sample_en;
    logic [9:0]   leds;
    logic [3:0]   position;
    logic         pos_valid;
    logic         direction;
    logic         bounce;
    logic         error;
    logic [W-1:0] error_count;
    logic [W-1:0] sweep_count;
    logic [1:0]   state;

    int n_vec = 0;
    int n_bad = 0;

    int m_mode, m_pos, m_valid, m_dir, m_bounce, m_err, m_ecnt, m_scnt;
    logic [25:0] exp_q[$];

    always #5 clk = ~clk;

    led_scan_decoder #(.ERR_CNT_W(W)) dut (
        .CLOCK_50    (clk),
        .reset       (rst),
        .sample_en   (sample_en),
        .LEDR_IN     (leds),
        .position    (position),
        .pos_valid   (pos_valid),
        .direction   (direction),
        .bounce      (bounce),
        .error       (error),
        .error_count (error_count),
        .sweep_count (sweep_count),
        .state       (state)
    );

    function automatic logic [9:0] oh(input int i);
        logic [9:0] one;
        one = 10'd1;
        return one << i;
    endfunction

    function automatic logic [25:0] dut_vec();
        return {state, position, pos_valid, direction, bounce, error, error_count, sweep_count};
    endfunction

    function automatic logic [25:0] exp_vec();
        return {2'(m_mode), 4'(m_pos), 1'(m_valid), 1'(m_dir), 1'(m_bounce), 1'(m_err),
                8'(m_ecnt), 8'(m_scnt)};
    endfunction

    function automatic void model_reset();
        m_mode = ST_IDLE; m_pos = 0; m_valid = 0; m_dir = 1;
        m_bounce = 0; m_err = 0; m_ecnt = 0; m_scnt = 0;
    endfunction

    // Tracking rule: after sync, each step must move by exactly one LED in the
    // current direction (or stay), reversing only at the ends of the bar.
    function automatic void model_step(input logic en, input logic [9:0] pat);
        int idx, delta;
        bit bad;
        m_bounce = 0;
        m_err = 0;
        if (!en) return;
        bad = ($countones(pat) != 1);
        idx = bad ? 0 : $clog2(pat);
        delta = idx - m_pos;
        if (!bad) begin
            case (m_mode)
                ST_IDLE: begin
                    m_pos = idx;
                    m_mode = (idx == 0) ? ST_UP : (idx == 9) ? ST_DOWN : ST_SYNC;
                end
                ST_SYNC: begin
                    if (delta == 1) begin m_pos = idx; m_mode = ST_UP; end
                    else if (delta == -1) begin m_pos = idx; m_mode = ST_DOWN; end
                    else if (delta != 0) bad = 1;
                end
                ST_UP: begin
                    if (delta == 1) m_pos = idx;
                    else if (m_pos == 9 && delta == -1) begin
                        m_pos = idx; m_mode = ST_DOWN; m_bounce = 1;
                    end else if (delta != 0) bad = 1;
                end
                default: begin
                    if (delta == -1) m_pos = idx;
                    else if (m_pos == 0 && delta == 1) begin
                        m_pos = idx; m_mode = ST_UP; m_bounce = 1;
                        m_scnt = (m_scnt + 1) % 256;
                    end else if (delta != 0) bad = 1;
                end
            endcase
        end
        if (bad) begin
            m_err = 1;
            m_mode = ST_IDLE;
            m_valid = 0;
            m_ecnt = (m_ecnt < 255) ? m_ecnt + 1 : 255;
        end else begin
            m_valid = 1;
        end
        if (m_mode == ST_UP) m_dir = 1;
        else if (m_mode == ST_DOWN) m_dir = 0;
    endfunction

    task automatic apply(input logic en, input logic [9:0] pat);
        @(negedge clk);
        sample_en = en;
        leds = pat;
        @(posedge clk);
        #1;
        model_step(en, pat);
        sample_en = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        sample_en = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        model_reset();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        sample_en = 1'b1;
        leds = oh(5);
        repeat (2) @(posedge clk);
        #1;
        model_reset();
        n_vec++;
        if (dut_vec() !== exp_vec()) begin
            n_bad++;
            $display("FAIL reset_state: got %h expected %h", dut_vec(), exp_vec());
        end
        n_vec++;
        if (direction !== 1'b1) begin
            n_bad++;
            $display("FAIL reset_direction: got %b expected 1", direction);
        end
        @(negedge clk);
        sample_en = 1'b0;
        rst = 1'b0;
    endtask

    task automatic test_sweep();
        int seq[20] = '{0, 1, 2, 3, 4, 5, 6, 7, 8, 9, 8, 7, 6, 5, 4, 3, 2, 1, 0, 1};
        do_reset();
        for (int k = 0; k < 20; k++) begin
            apply(1'b1, oh(seq[k]));
            n_vec++;
            if (dut_vec() !== exp_vec()) begin
                n_bad++;
                $display("FAIL sweep_step_%0d: got %h expected %h", k, dut_vec(), exp_vec());
            end
            n_vec++;
            if (bounce !== ((k == 10) || (k == 19))) begin
                n_bad++;
                $display("FAIL sweep_bounce_%0d: got %b expected %b", k, bounce, (k == 10) || (k == 19));
            end
        end
        n_vec++;
        if (sweep_count !== 8'd1 || error_count !== 8'd0 || pos_valid !== 1'b1) begin
            n_bad++;
            $display("FAIL sweep_counts: got sweep %0d err %0d valid %b expected 1 0 1",
                     sweep_count, error_count, pos_valid);
        end
    endtask

    task automatic test_illegal_pattern();
        do_reset();
        for (int k = 0; k <= 3; k++) apply(1'b1, oh(k));
        apply(1'b1, 10'b0000110000);
        n_vec++;
        if (dut_vec() !== exp_vec()) begin
            n_bad++;
            $display("FAIL two_hot: got %h expected %h", dut_vec(), exp_vec());
        end
        n_vec++;
        if (error !== 1'b1 || pos_valid !== 1'b0 || position !== 4'd3 ||
            state !== 2'(ST_IDLE) || error_count !== 8'd1) begin
            n_bad++;
            $display("FAIL two_hot_fields: got err %b valid %b pos %0d st %0d cnt %0d expected 1 0 3 0 1",
                     error, pos_valid, position, state, error_count);
        end
    endtask

    task automatic test_resync();
        do_reset();
        for (int k = 0; k <= 4; k++) apply(1'b1, oh(k));
        apply(1'b1, oh(6));
        n_vec++;
        if (error !== 1'b1 || pos_valid !== 1'b0 || dut_vec() !== exp_vec()) begin
            n_bad++;
            $display("FAIL skip_error: got %h expected %h", dut_vec(), exp_vec());
        end
        apply(1'b1, oh(6));
        n_vec++;
        if (pos_valid !== 1'b1 || state !== 2'(ST_SYNC) || position !== 4'd6) begin
            n_bad++;
            $display("FAIL resync: got valid %b st %0d pos %0d expected 1 1 6", pos_valid, state, position);
        end
        apply(1'b1, oh(5));
        n_vec++;
        if (state !== 2'(ST_DOWN) || direction !== 1'b0 || dut_vec() !== exp_vec()) begin
            n_bad++;
            $display("FAIL sync_to_down: got %h expected %h", dut_vec(), exp_vec());
        end
    endtask

    task automatic test_hold_and_idle();
        do_reset();
        for (int k = 0; k <= 5; k++) apply(1'b1, oh(k));
        for (int k = 0; k < 4; k++) begin
            apply(1'b1, oh(5));
            n_vec++;
            if (error !== 1'b0 || bounce !== 1'b0 || position !== 4'd5 || dut_vec() !== exp_vec()) begin
                n_bad++;
                $display("FAIL hold_%0d: got %h expected %h", k, dut_vec(), exp_vec());
            end
        end
        for (int k = 0; k < 20; k++) begin
            apply(1'b0, 10'($urandom));
            n_vec++;
            if (dut_vec() !== exp_vec()) begin
                n_bad++;
                $display("FAIL idle_%0d: got %h expected %h", k, dut_vec(), exp_vec());
            end
        end
    endtask

    task automatic test_saturation();
        do_reset();
        for (int k = 0; k < 300; k++) begin
            apply(1'b1, 10'd0);
            n_vec++;
            if (dut_vec() !== exp_vec()) begin
                n_bad++;
                $display("FAIL zero_%0d: got %h expected %h", k, dut_vec(), exp_vec());
            end
        end
        n_vec++;
        if (error_count !== 8'd255) begin
            n_bad++;
            $display("FAIL err_saturate: got %0d expected 255", error_count);
        end
        do_reset();
        apply(1'b1, oh(0));
        for (int s = 0; s < 256; s++) begin
            for (int k = 1; k <= 9; k++) apply(1'b1, oh(k));
            for (int k = 8; k >= 0; k--) apply(1'b1, oh(k));
            n_vec++;
            if (dut_vec() !== exp_vec()) begin
                n_bad++;
                $display("FAIL sweep_%0d: got %h expected %h", s, dut_vec(), exp_vec());
            end
        end
        n_vec++;
        if (sweep_count !== 8'd255) begin
            n_bad++;
            $display("FAIL sweep_255: got %0d expected 255", sweep_count);
        end
        apply(1'b1, oh(1));
        n_vec++;
        if (sweep_count !== 8'd0 || bounce !== 1'b1) begin
            n_bad++;
            $display("FAIL sweep_wrap: got %0d bounce %b expected 0 1", sweep_count, bounce);
        end
    endtask

    task automatic test_async_reset();
        do_reset();
        for (int k = 0; k <= 7; k++) apply(1'b1, oh(k));
        @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        model_reset();
        n_vec++;
        if (dut_vec() !== exp_vec()) begin
            n_bad++;
            $display("FAIL async_reset: got %h expected %h", dut_vec(), exp_vec());
        end
        @(negedge clk);
        rst = 1'b0;
        apply(1'b1, oh(7));
        n_vec++;
        if (state !== 2'(ST_SYNC) || pos_valid !== 1'b1 || position !== 4'd7) begin
            n_bad++;
            $display("FAIL post_reset_sync: got st %0d valid %b pos %0d expected 1 1 7",
                     state, pos_valid, position);
        end
    endtask

    task automatic test_random();
        logic [25:0] e;
        logic [9:0] pat;
        int r, p;
        do_reset();
        for (int k = 0; k < 2000; k++) begin
            r = $urandom_range(0, 9);
            p = m_pos;
            if (r < 5) p = ($urandom_range(0, 1) == 1) ? p + 1 : p - 1;
            if (p < 0) p = 1;
            if (p > 9) p = 8;
            if (r < 7) pat = oh(p);
            else if (r < 8) pat = oh($urandom_range(0, 9));
            else pat = 10'($urandom);
            apply($urandom_range(0, 7) != 0, pat);
            exp_q.push_back(exp_vec());
            e = exp_q.pop_front();
            n_vec++;
            if (dut_vec() !== e || (bounce && error)) begin
                n_bad++;
                $display("FAIL random_%0d: got %h expected %h", k, dut_vec(), e);
            end
        end
    endtask

    initial begin
        sample_en = 1'b0;
        leds = 10'd0;
        rst = 1'b0;
        model_reset();
        test_reset();
        test_sweep();
        test_illegal_pattern();
        test_resync();
        test_hold_and_idle();
        test_saturation();
        test_async_reset();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
